// File: rtl/if_prefetch_if.sv
// -----------------------------------------------------------------------------
// if_prefetch_if
// Instruction-memory request/acknowledge port used by the fetch front end.
//   mem_req   : fetch request, held high until the matching ack
//   mem_addr  : fetch word address, stable while mem_req=1 and no ack
//   mem_ack   : one-cycle response strobe, only meaningful while mem_req=1
//   mem_rdata : instruction word, sampled when mem_ack=1
// Modports: master = fetch unit (drives the request), slave = memory.
// -----------------------------------------------------------------------------
interface if_prefetch_if #(
  parameter int PC_W = 8
);
  logic            mem_req;
  logic [PC_W-1:0] mem_addr;
  logic            mem_ack;
  logic [31:0]     mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/if_prefetch.sv
// -----------------------------------------------------------------------------
// if_prefetch
// Instruction-fetch front end with a DEPTH-entry prefetch queue. Holds the
// fetch PC, issues one outstanding request at a time to a variable-latency
// instruction memory, queues the returned words and presents the head entry
// to the fetch/decode buffer. Branch/jump redirects flush the queue; a request
// already in flight at redirect time is completed and its data dropped.
//
// Ports:
//   clk, rst        : clock; asynchronous active-low reset
//   stall           : downstream hold, head entry is not consumed
//   branch_taken    : redirect to branch_pc
//   branch_pc       : branch target
//   jmp             : redirect to jmp_pc (wins over branch_taken)
//   jmp_pc          : jump target
//   mem             : instruction-memory port (master side)
//   out_valid       : queue head holds a valid instruction
//   out_instr       : head instruction, 32'h0 when out_valid=0
//   out_pc          : head instruction address
//   out_next_pc     : out_pc + 1 (wraps)
// -----------------------------------------------------------------------------
module if_prefetch #(
  parameter int              PC_W     = 8,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_pc,
  input  logic              jmp,
  input  logic [PC_W-1:0]   jmp_pc,
  if_prefetch_if.master     mem,
  output logic              out_valid,
  output logic [31:0]       out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic [PC_W-1:0]   out_next_pc
);

  localparam int                PTR_W = $clog2(DEPTH);
  localparam int                CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,  // no request outstanding
    S_REQ,   // request for fpc outstanding
    S_DROP   // request outstanding whose data is stale after a redirect
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    fpc_q, fpc_d;
  logic [PC_W-1:0]    addr_q, addr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [31:0]        q_instr [DEPTH];
  logic [PC_W-1:0]    q_pc    [DEPTH];

  logic               redirect;
  logic [PC_W-1:0]    target;
  logic               ack;
  logic               push;
  logic               pop;

  assign redirect = jmp | branch_taken;
  assign target   = jmp ? jmp_pc : branch_pc;
  // An ack is only meaningful while a request is outstanding.
  assign ack      = mem.mem_ack & (state_q != S_IDLE);
  assign out_valid = (count_q != '0);
  // A redirect flushes the queue, so it suppresses both the push of a
  // same-cycle response and the consumption of the head.
  assign push     = (state_q == S_REQ) & ack & ~redirect;
  assign pop      = out_valid & ~stall & ~redirect;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (redirect) begin
      fpc_d    = target;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        fpc_d    = fpc_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    unique case (state_q)
      S_IDLE: begin
        state_d = (count_d < FULL) ? S_REQ : S_IDLE;
      end
      S_REQ: begin
        if (ack) begin
          state_d = (count_d < FULL) ? S_REQ : S_IDLE;
        end else if (redirect) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        // A second redirect while the stale request is still pending keeps
        // waiting for it: only one request may ever be outstanding.
        if (ack) begin
          state_d = (count_d < FULL) ? S_REQ : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The memory address is a separate register so it stays frozen for the
  // whole life of a request, including a DROP where fpc already points at
  // the redirect target. It reloads only when no request is held open.
  assign addr_d = ((state_q == S_IDLE) || ack) ? fpc_d : addr_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      fpc_q    <= RESET_PC;
      addr_q   <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      addr_q   <= addr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: queue storage is deliberately not reset; count_q gates every read,
  // so stale contents are never visible and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr_q] <= mem.mem_rdata;
      q_pc[wr_ptr_q]    <= fpc_q;
    end
  end

  assign mem.mem_req  = (state_q != S_IDLE);
  assign mem.mem_addr = addr_q;

  assign out_instr   = out_valid ? q_instr[rd_ptr_q] : 32'h0;
  assign out_pc      = out_valid ? q_pc[rd_ptr_q]    : '0;
  assign out_next_pc = out_pc + 1'b1;

endmodule

// File: tb/tb_if_prefetch.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_if_prefetch
// Scoreboard bench: the driver pushes the expected out_pc sequence for each
// directed scenario into exp_q; an independent monitor pops and compares on
// every consumed head. A behavioural memory answers with rdata = addr + 0x100
// after a programmable number of wait cycles.
// -----------------------------------------------------------------------------
module tb_if_prefetch;
  localparam int PC_W  = 8;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stall = 1'b1;
  logic              branch_taken = 1'b0;
  logic              jmp = 1'b0;
  logic [PC_W-1:0]   branch_pc = '0;
  logic [PC_W-1:0]   jmp_pc = '0;
  logic              out_valid;
  logic [31:0]       out_instr;
  logic [PC_W-1:0]   out_pc;
  logic [PC_W-1:0]   out_next_pc;

  if_prefetch_if #(.PC_W(PC_W)) mem ();

  if_prefetch #(.PC_W(PC_W), .DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_pc    (branch_pc),
    .jmp          (jmp),
    .jmp_pc       (jmp_pc),
    .mem          (mem),
    .out_valid    (out_valid),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_next_pc  (out_next_pc)
  );

  always #5 clk = ~clk;

  int              n_cmp = 0;
  int              n_bad = 0;
  logic [PC_W-1:0] exp_q[$];
  logic            stall_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- memory model (acts at negedge+0) ----------------
  int              lat = 0;
  int              mem_cnt = 0;
  logic            req_open = 1'b0;
  logic [PC_W-1:0] req_addr = '0;

  initial begin
    mem.mem_ack   = 1'b0;
    mem.mem_rdata = 32'h0;
  end

  always @(negedge clk) begin
    if (!rst || !mem.mem_req) begin
      mem.mem_ack = 1'b0;
      mem_cnt     = 0;
      req_open    = 1'b0;
    end else begin
      if (req_open) check("addr_hold", {24'h0, mem.mem_addr}, {24'h0, req_addr});
      else begin
        req_addr = mem.mem_addr;
        req_open = 1'b1;
      end
      if (mem_cnt >= lat) begin
        mem.mem_ack   = 1'b1;
        mem.mem_rdata = {24'h0, req_addr} + 32'h100;
        mem_cnt       = 0;
        req_open      = 1'b0;
      end else begin
        mem.mem_ack   = 1'b0;
        mem.mem_rdata = 32'hDEAD_BEEF;
        mem_cnt++;
      end
    end
  end

  // ---------------- monitor (samples at negedge+2) ----------------
  logic [PC_W-1:0] mon_e;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      if (!out_valid) begin
        check("nop_instr", out_instr, 32'h0);
      end else if (!stall && !jmp && !branch_taken) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pop: got pc %0h expected none", out_pc);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_pc", {24'h0, out_pc}, {24'h0, mon_e});
          check("out_instr", out_instr, {24'h0, mon_e} + 32'h100);
          check("out_next_pc", {24'h0, out_next_pc}, {24'h0, mon_e + 8'h01});
        end
      end
    end
  end

  // ---------------- driver helpers (act at negedge+1) ----------------
  // Stall also gates consumption once the expected list is exhausted, so the
  // monitor never sees heads it was not told about.
  task automatic step();
    @(negedge clk);
    #1;
    stall = stall_req || (exp_q.size() == 0);
  endtask

  task automatic load(input logic [PC_W-1:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + PC_W'(i));
  endtask

  // Caller is positioned at negedge+1 of the redirect cycle; returns at
  // negedge+1 of the following cycle with the redirect released.
  task automatic redirect(input logic j, input logic b, input logic [PC_W-1:0] jpc,
                          input logic [PC_W-1:0] bpc, input logic [PC_W-1:0] base, input int n);
    jmp          = j;
    branch_taken = b;
    jmp_pc       = jpc;
    branch_pc    = bpc;
    exp_q.delete();
    load(base, n);
    stall = stall_req || (exp_q.size() == 0);
    step();
    jmp          = 1'b0;
    branch_taken = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      step();
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"},   {31'h0, mem.mem_req}, 32'h0);
    check({tag, "_mem_addr"},  {24'h0, mem.mem_addr}, 32'h0);
    check({tag, "_out_valid"}, {31'h0, out_valid}, 32'h0);
    check({tag, "_out_instr"}, out_instr, 32'h0);
    check({tag, "_out_pc"},    {24'h0, out_pc}, 32'h0);
    check({tag, "_next_pc"},   {24'h0, out_next_pc}, 32'h1);
  endtask

  initial begin
    int nv;
    int k;
    logic [PC_W-1:0] old_addr;

    #2 rst = 1'b0;
    step();
    step();
    check_reset_outputs("rst");

    // ---- zero-wait streaming ----
    load(8'h00, 24);
    stall = 1'b0;
    rst   = 1'b1;                       // cycle 0
    step();                             // cycle 1
    check("c1_mem_req",   {31'h0, mem.mem_req}, 32'h1);
    check("c1_mem_addr",  {24'h0, mem.mem_addr}, 32'h0);
    check("c1_out_valid", {31'h0, out_valid}, 32'h0);
    step();                             // cycle 2
    check("c2_out_valid", {31'h0, out_valid}, 32'h1);
    check("c2_out_pc",    {24'h0, out_pc}, 32'h0);
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) nv++;
      step();
    end
    check("zero_wait_throughput", nv, 20);
    wait_drain("drain_stream", 20);

    // ---- 3-cycle memory latency ----
    lat = 3;
    repeat (4) step();
    redirect(1'b1, 1'b0, 8'h10, 8'h00, 8'h10, 16);
    check("lat_redir_valid", {31'h0, out_valid}, 32'h0);
    check("lat_redir_req",   {31'h0, mem.mem_req}, 32'h1);
    check("lat_redir_addr",  {24'h0, mem.mem_addr}, 32'h10);
    k = 0;
    while (!out_valid && k < 20) begin
      step();
      k++;
    end
    check("lat_first_valid", {31'h0, out_valid}, 32'h1);
    nv = 0;
    for (int i = 0; i < 16; i++) begin
      if (out_valid) nv++;
      step();
    end
    check("lat_pulse_count", nv, 4);

    // ---- jump while a request is outstanding ----
    k = 0;
    while (!(mem.mem_req && mem_cnt == 1) && k < 40) begin
      step();
      k++;
    end
    check("outstanding_found", {31'h0, (mem.mem_req && mem_cnt == 1)}, 32'h1);
    old_addr = mem.mem_addr;
    redirect(1'b1, 1'b0, 8'h40, 8'h00, 8'h40, 3);
    check("drop_valid", {31'h0, out_valid}, 32'h0);
    check("drop_req",   {31'h0, mem.mem_req}, 32'h1);
    check("drop_addr",  {24'h0, mem.mem_addr}, {24'h0, old_addr});
    wait_drain("drain_jmp40", 60);

    // ---- jmp and branch together: jmp wins ----
    lat = 0;
    repeat (8) step();
    redirect(1'b1, 1'b1, 8'h80, 8'h20, 8'h80, 4);
    check("both_valid", {31'h0, out_valid}, 32'h0);
    check("both_addr",  {24'h0, mem.mem_addr}, 32'h80);
    wait_drain("drain_both", 30);

    // ---- branch to 0xFE, PC wrap ----
    repeat (8) step();
    redirect(1'b0, 1'b1, 8'h55, 8'hFE, 8'hFE, 4);
    check("wrap_addr", {24'h0, mem.mem_addr}, 32'hFE);
    wait_drain("drain_wrap", 30);

    // ---- stall held for 10 cycles ----
    repeat (8) step();
    stall_req = 1'b1;
    redirect(1'b1, 1'b0, 8'h30, 8'h00, 8'h30, 8);
    repeat (4) step();
    check("stall_mid_pc", {24'h0, out_pc}, 32'h30);
    repeat (6) step();
    check("stall_mem_req", {31'h0, mem.mem_req}, 32'h0);
    check("stall_valid",   {31'h0, out_valid}, 32'h1);
    check("stall_pc",      {24'h0, out_pc}, 32'h30);
    check("stall_instr",   out_instr, 32'h130);
    stall_req = 1'b0;
    wait_drain("drain_stall", 30);

    // ---- reset mid-burst with an ack pending ----
    repeat (8) step();
    lat       = 3;
    stall_req = 1'b1;
    redirect(1'b1, 1'b0, 8'h50, 8'h00, 8'h50, 6);
    k = 0;
    while (!(out_valid && mem.mem_req && mem_cnt == 2) && k < 40) begin
      step();
      k++;
    end
    check("pre_rst_busy", {31'h0, (out_valid && mem.mem_req && mem_cnt == 2)}, 32'h1);
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    exp_q.delete();
    stall_req = 1'b0;
    step();
    step();
    lat = 0;
    load(8'h00, 6);
    stall = 1'b0;
    rst   = 1'b1;
    step();
    check("restart_req",  {31'h0, mem.mem_req}, 32'h1);
    check("restart_addr", {24'h0, mem.mem_addr}, 32'h0);
    wait_drain("drain_restart", 30);

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog: ends the run if the directed sequence hangs.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_prefetch.md
# if_prefetch

Instruction-fetch front end with a small prefetch queue. It sits directly upstream of the fetch/decode pipeline buffer and replaces the combinational PC-to-ROM path with a request/acknowledge instruction-memory port, so that instruction memory may have variable latency. It holds the fetch PC and issues fetches ahead of decode into a DEPTH-entry queue. It takes branch and jump redirects from the memory stage and honours stalls from the hazard unit.

## Interface
- PC_W, 8: program-counter width; word address, matching ProgramCounter.
- DEPTH, 4: prefetch queue entries; power of two, ≥2.
- RESET_PC, 0: fetch address after reset.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; one clock; asynchronous, active-low (rst=0 resets).
- stall  in  1  downstream hold (hazard stallIF); head entry is not consumed.
- branch_taken  in  1  M-stage branch with alu_zero; redirect to branch_pc.
- branch_pc  in  PC_W  branch target.
- jmp  in  1  M-stage jump; redirect to jmp_pc; wins over branch_taken.
- jmp_pc  in  PC_W  jump target.
- mem_req  out  1  fetch request to instruction memory.
- mem_addr  out  PC_W  fetch word address; stable while mem_req=1 and no ack.
- mem_ack  in  1  one-cycle response strobe; only valid while mem_req=1.
- mem_rdata  in  32  instruction; sampled when mem_ack=1.
- out_valid  out  1  queue head holds a valid instruction.
- out_instr  out  32  head instruction; 32'h0 (NOP) when out_valid=0.
- out_pc  out  PC_W  head instruction address.
- out_next_pc  out  PC_W  out_pc+1 mod 2^PC_W; feeds FD next_pc_i.

## Operation
- State: fetch PC `fpc`; circular queue of DEPTH entries of {instr, pc} with read/write pointers and `count`; 3-state FSM.
  - IDLE: mem_req=0.
  - REQ: mem_req=1, mem_addr=fpc.
  - DROP: mem_req=1; the response will be discarded.
- Invariant: count + (state≠IDLE ? 1 : 0) ≤ DEPTH. At most one request is outstanding.
- Pop: out_valid & !stall & no redirect. Pointers wrap mod DEPTH.
- Redirect (jmp | branch_taken):
  - Target is jmp ? jmp_pc : branch_pc.
  - Queue is flushed: count=0 and pointers reset.
  - fpc ← target.
  - If state=REQ and mem_ack=0, next state is DROP. Otherwise the next state is chosen as for IDLE with the queue empty.
  - A mem_ack arriving in the redirect cycle is discarded.
  - A redirect overrides stall and any same-cycle pop.
- REQ with mem_ack=1 (no redirect):
  - Push {mem_rdata, fpc}; fpc ← fpc+1.
  - Stay in REQ if post-update count < DEPTH, else go to IDLE.
- REQ with mem_ack=0: hold fpc and mem_addr.
- DROP with mem_ack=1: discard the data. Go to REQ (queue is empty), fetching the new fpc.
- DROP with mem_ack=0: hold.
- IDLE: go to REQ when post-update count < DEPTH.
- Push and pop in the same cycle leave count unchanged. Push into a full queue cannot occur, by the invariant.
- fpc wraps from 2^PC_W−1 to 0 with no special handling.

## Timing
- Reset values (asynchronous):
  - fpc=RESET_PC, FSM=IDLE, count=0.
  - mem_req=0, mem_addr=RESET_PC.
  - out_valid=0, out_instr=0, out_pc=0, out_next_pc=1.
- First edge after rst rises: IDLE→REQ. mem_req=1 in cycle 1.
- mem_ack may arrive in the same cycle mem_req is first high (zero-wait memory).
  - Sustained throughput is then 1 instruction/cycle.
  - The pushed entry appears on out_* the cycle after the ack edge.
- Redirect latency:
  - Redirect is asserted in cycle t.
  - out_valid=0 in cycle t+1.
  - The target request is on mem_addr by t+1 (no outstanding request), or after the dropped ack.
- All outputs are registered or decoded from registered state only. There is no combinational path from stall, jmp or branch_taken to mem_req or out_*.
- rst asserted mid-operation clears everything immediately; an in-flight ack is ignored.

## Test plan
- Zero-wait memory, rdata=addr+0x100, no stall:
  - mem_req=1 from cycle 1.
  - out_valid from cycle 2.
  - out_pc = 0,1,2,… consecutive.
  - out_next_pc = out_pc+1.
- Memory acks 3 cycles after each request:
  - mem_addr is held stable until ack.
  - out_valid pulses once per 4 cycles.
  - No instruction is duplicated or lost.
- stall held high for 10 cycles, zero-wait memory:
  - count reaches 4; mem_req=0.
  - out_pc is frozen at head.
  - Releasing stall resumes in order.
- jmp=1, jmp_pc=0x40 while a 3-cycle request is outstanding:
  - Queue flushes; DROP discards the late ack.
  - Next out_pc=0x40.
  - jmp and branch_taken together: target = jmp_pc.
- Redirect to 0xFE:
  - out_pc sequence 0xFE, 0xFF, 0x00, 0x01.
- rst dropped low mid-burst with ack pending:
  - All outputs are at reset values in the same cycle.
  - After release, fetch restarts at RESET_PC.
